// File: rtl/trng_sampler.sv
// trng_sampler: synchronises a raw oscillator bit, samples it, debiases it with a von Neumann
// corrector, health-checks repetition runs and packs the result into bytes on valid/ready.
module trng_sampler #(
    parameter int SAMPLE_DIV = 8,
    parameter int REP_LIMIT  = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       rnd_in,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       fault_o
);
    logic       r1, s, run, strobe, phase, first, last, emit, trip, xfer, full;
    logic [7:0] div_cnt, rep_cnt, sh, nb;
    logic [2:0] bit_cnt;
    assign run    = en && !fault_o;
    assign strobe = run && div_cnt == 8'(SAMPLE_DIV - 1);
    assign emit   = strobe && phase && first != s;
    assign trip   = rep_cnt == 8'(REP_LIMIT);
    assign xfer   = valid_o && ready_i;
    assign nb     = {sh[6:0], first};
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r1      <= 1'b0;
            s       <= 1'b0;
            div_cnt <= '0;
        end else begin
            r1      <= rnd_in;
            s       <= r1;
            div_cnt <= (strobe || !run) ? 8'd0 : div_cnt + 8'd1;
        end
    // rep_cnt==0 marks "no previous sample" so the first sample after enable starts a fresh run
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            rep_cnt <= '0;
            last    <= 1'b0;
            phase   <= 1'b0;
            first   <= 1'b0;
        end else if (!run) begin
            rep_cnt <= '0;
            phase   <= 1'b0;
        end else if (strobe) begin
            rep_cnt <= (rep_cnt != 0 && s == last) ? rep_cnt + 8'd1 : 8'd1;
            last    <= s;
            phase   <= !phase;
            if (!phase)
                first <= s;
        end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            data_o  <= '0;
            valid_o <= 1'b0;
            fault_o <= 1'b0;
            full    <= 1'b0;
            sh      <= '0;
            bit_cnt <= '0;
        end else if (fault_o || trip) begin
            fault_o <= 1'b1;
            valid_o <= 1'b0;
            full    <= 1'b0;
            bit_cnt <= '0;
        end else begin
            if (xfer) begin
                valid_o <= full;
                if (full) begin
                    data_o <= sh;
                    full   <= 1'b0;
                end
            end
            if (!en)
                bit_cnt <= '0;
            else if (emit && !full) begin
                sh      <= nb;
                bit_cnt <= bit_cnt + 3'd1;
                // a completed byte parks in sh when the output slot is still occupied
                if (bit_cnt == 3'd7) begin
                    if (!valid_o || xfer) begin
                        data_o  <= nb;
                        valid_o <= 1'b1;
                    end else
                        full <= 1'b1;
                end
            end
        end
endmodule
